// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Fetch, data and RAM-side signals of the shared 16-bit RAM port.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
    parameter int ADDR_W = 18
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              if_ready;
    logic              if_stall;
    logic              mem_req;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;
    logic              mem_stall;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we_n;
    logic [15:0]       ram_wdata;
    logic [15:0]       ram_rdata;
    logic              busy;

    // Requesters and the RAM device
    modport master (
        output if_req, if_addr, mem_req, mem_rw, mem_addr, mem_wdata, ram_rdata,
        input  if_rdata, if_ready, if_stall, mem_rdata, mem_ready, mem_stall,
               ram_addr, ram_we_n, ram_wdata, busy
    );

    // The arbiter
    modport slave (
        input  if_req, if_addr, mem_req, mem_rw, mem_addr, mem_wdata, ram_rdata,
        output if_rdata, if_ready, if_stall, mem_rdata, mem_ready, mem_stall,
               ram_addr, ram_we_n, ram_wdata, busy
    );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one 16-bit RAM port between fetch and memory stage,
//               moving each 32-bit word as high half then low half.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W = 18
) (
    input  logic              clock,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    localparam logic [ADDR_W-1:0] c_HALF_SEL = ADDR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2
    } state_t;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_MEM   = 1'b1
    } gnt_t;

    state_t      r_state;
    gnt_t        r_gnt;
    logic [15:0] r_hi_q;

    logic              w_is_mem;
    logic              w_write;
    logic              w_active;
    logic              w_lo;
    logic [ADDR_W-1:0] w_addr;

    // Reset gates the port so an aborted transfer issues no ready or write.
    always_comb begin
        w_is_mem = (r_gnt == GNT_MEM);
        w_addr   = w_is_mem ? bus.mem_addr : bus.if_addr;
        w_write  = w_is_mem & bus.mem_rw;
        w_active = ~reset & (r_state != ST_IDLE);
        w_lo     = ~reset & (r_state == ST_LO);
    end

    assign bus.ram_addr  = w_active ? ((w_addr & ~c_HALF_SEL) | (w_lo ? c_HALF_SEL : '0))
                                    : '0;
    assign bus.ram_we_n  = ~(w_active & w_write);
    assign bus.ram_wdata = (r_state == ST_LO) ? bus.mem_wdata[15:0] : bus.mem_wdata[31:16];

    assign bus.if_ready  = w_lo & ~w_is_mem;
    assign bus.mem_ready = w_lo & w_is_mem;
    assign bus.if_stall  = bus.if_req & ~bus.if_ready;
    assign bus.mem_stall = bus.mem_req & ~bus.mem_ready;
    assign bus.if_rdata  = {r_hi_q, bus.ram_rdata};
    assign bus.mem_rdata = {r_hi_q, bus.ram_rdata};
    assign bus.busy      = (r_state != ST_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_gnt   <= GNT_MEM;
            r_hi_q  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.mem_req) begin
                        r_state <= ST_HI;
                        r_gnt   <= GNT_MEM;
                    end else if (bus.if_req) begin
                        r_state <= ST_HI;
                        r_gnt   <= GNT_FETCH;
                    end
                end
                ST_HI: begin
                    if (!w_write) begin
                        r_hi_q <= bus.ram_rdata;
                    end
                    r_state <= ST_LO;
                end
                ST_LO: begin
                    // Hand over to the other requester without an idle cycle.
                    if (w_is_mem && bus.if_req) begin
                        r_state <= ST_HI;
                        r_gnt   <= GNT_FETCH;
                    end else if (!w_is_mem && bus.mem_req) begin
                        r_state <= ST_HI;
                        r_gnt   <= GNT_MEM;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

`default_nettype wire
